load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage of the arriskv core: sits directly downstream of execute and consumes its resolved load/store operation (address, store data, destination register).
- Drives a word-addressed data-memory port with byte enables and a req/gnt/rvalid handshake.
- Aligns and extends load data, then issues a single-cycle register-file write.
- Detects misaligned and illegal-size accesses; these never reach memory.

Parameters:
- wd_regs_p, 32, register/data width (fixed at 32 for RV32).
- n_regs_p, 32, register count; wd_addr_p = $clog2(n_regs_p) is derived and not overridable.
- wd_ramaddr_p, 32, data-memory byte-address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- i_lsu_valid  in  1  execute presents a memory op.
- o_lsu_ready  out  1  unit can accept an op this cycle.
- i_lsu_op  in  mem_op_t  {is_store, is_unsigned, size[1:0]}.
- i_lsu_addr  in  wd_ramaddr_p  byte address.
- i_lsu_wdata  in  wd_regs_p  store data (rs2).
- i_lsu_rd  in  wd_addr_p  load destination register.
- o_mem_req  out  1  memory request.
- i_mem_gnt  in  1  request accepted.
- o_mem_we  out  1  store when 1.
- o_mem_addr  out  wd_ramaddr_p  word-aligned address ([1:0]=0).
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  wd_regs_p  lane-replicated store data.
- i_mem_rvalid  in  1  load data valid.
- i_mem_rdata  in  wd_regs_p  load word.
- o_wb_en  out  1  register write strobe.
- o_wb_addr  out  wd_addr_p  register write address.
- o_wb_data  out  wd_regs_p  extended load data.
- o_exc  out  1  exception pulse.
- o_exc_cause  out  1  0 = misaligned, 1 = illegal size.
- o_busy  out  1  op in flight.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: FSM goes to IDLE. All outputs are 0 except o_lsu_ready, which is 1. Any in-flight access is abandoned and no writeback is issued for it.
- FSM states:
  - IDLE: o_lsu_ready=1. An op is accepted when i_lsu_valid&&o_lsu_ready. A legal op registers its fields and moves to REQ. An illegal op stays in IDLE.
  - REQ: o_mem_req=1. addr, we, be and wdata are held stable until i_mem_gnt. On gnt, a store returns to IDLE and a load moves to WAIT.
  - WAIT: waits for i_mem_rvalid, then returns to IDLE.
- o_busy = (state != IDLE). o_lsu_ready = (state == IDLE).
- Outputs are registered. o_mem_req rises the cycle after accept, so the minimum store occupancy is 2 cycles.
- Writeback (loads):
  - o_wb_en pulses for 1 cycle, the cycle after rvalid is sampled in WAIT.
  - Minimum load latency is 3 cycles from accept to o_wb_en.
  - o_wb_en is suppressed when rd == 0, but the memory access still occurs.
- Memory port rules:
  - i_mem_rvalid is ignored outside WAIT.
  - rvalid in the same cycle as gnt is ignored; memory guarantees rvalid no earlier than one cycle after gnt.
  - i_mem_gnt is ignored outside REQ.
- Exceptions:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: size=2'b11.
  - Either case causes no memory access and no writeback. o_exc pulses 1 cycle, the cycle after accept, with o_exc_cause set. The FSM stays in IDLE.
- Store lane rules (off = addr[1:0]):
  - SB: be = 4'b0001 << off, wdata = {4{byte0}}.
  - SH: be = 4'b0011 << off, wdata = {2{half0}}.
  - SW: be = 4'b1111, wdata passed through.
  - Loads drive be = 4'b1111.
- Load extract:
  - shifted = rdata >> (8*off).
  - Byte uses [7:0] and half uses [15:0]; each is sign-extended, or zero-extended if is_unsigned. Word passes through.
- The address, size, unsigned flag and rd are captured at accept and used for the extract; execute may change its inputs freely after accept.

Decomposition:
- arriskv_pkg gains:
  - mem_size_e (MEM_B=0, MEM_H=1, MEM_W=2).
  - mem_op_t packed struct.
  - lsu_state_e (IDLE, REQ, WAIT).
  - lsu_exc_e (EXC_MISALIGNED=0, EXC_ILLEGAL_SIZE=1).
- One combinational sub-module, lsu_data_align, contains the store lane replication, byte-enable generation, load shift/extend and misalignment check. The FSM and registers stay in load_store_unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt held low 3 cycles: mem_addr=0x100, be=1111, req and fields stable for all 3 stall cycles, then IDLE the cycle after gnt; no wb_en.
- SB addr=0x103, wdata=0x000000A5: be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x202, rd=7, rdata=0x12F03456 returned 2 cycles after gnt: wb_en once, wb_addr=7, wb_data=0xFFFFFFF0. Same access as LBU gives 0x000000F0.
- LH addr=0x201: o_exc=1, cause=0, o_mem_req never asserts; size=2'b11 at addr 0x200 gives cause=1.
- LW rd=0, rdata=0xCAFEBABE: full req/gnt/rvalid handshake completes, o_wb_en stays 0.
- rst asserted while in WAIT, rvalid arrives after release: FSM in IDLE immediately, all outputs 0, no wb_en; a subsequent SW completes normally.

Source files
------------

// File: rtl/arriskv_pkg.sv
// Shared arriskv types for the memory stage: access size, op encoding, LSU state and exception cause.
// Pure declarations, no latency; no flow control.
// Imported by the LSU, its interface and the alignment datapath.
package arriskv_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // size is a raw 2-bit field so the reserved encoding 2'b11 can be carried and rejected
    typedef struct packed {
        logic       is_store;
        logic       is_unsigned;
        logic [1:0] size;
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    typedef enum logic {
        EXC_MISALIGNED   = 1'b0,
        EXC_ILLEGAL_SIZE = 1'b1
    } lsu_exc_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles the execute-side op handshake, data-memory port and writeback/exception outputs of the LSU.
// Wires only, no latency; execute uses valid/ready, memory uses req/gnt/rvalid.
// The slave modport is the LSU view; master is the surrounding core or bench.
interface load_store_unit_if #(
    parameter int wd_regs_p    = 32,
    parameter int n_regs_p     = 32,
    parameter int wd_ramaddr_p = 32
) ();
    import arriskv_pkg::*;

    localparam int wd_addr_p = $clog2(n_regs_p);

    logic                    i_lsu_valid;
    logic                    o_lsu_ready;
    mem_op_t                 i_lsu_op;
    logic [wd_ramaddr_p-1:0] i_lsu_addr;
    logic [wd_regs_p-1:0]    i_lsu_wdata;
    logic [wd_addr_p-1:0]    i_lsu_rd;

    logic                    o_mem_req;
    logic                    i_mem_gnt;
    logic                    o_mem_we;
    logic [wd_ramaddr_p-1:0] o_mem_addr;
    logic [3:0]              o_mem_be;
    logic [wd_regs_p-1:0]    o_mem_wdata;
    logic                    i_mem_rvalid;
    logic [wd_regs_p-1:0]    i_mem_rdata;

    logic                    o_wb_en;
    logic [wd_addr_p-1:0]    o_wb_addr;
    logic [wd_regs_p-1:0]    o_wb_data;
    logic                    o_exc;
    logic                    o_exc_cause;
    logic                    o_busy;

    modport slave (
        input  i_lsu_valid, i_lsu_op, i_lsu_addr, i_lsu_wdata, i_lsu_rd,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_lsu_ready,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        output o_wb_en, o_wb_addr, o_wb_data, o_exc, o_exc_cause, o_busy
    );

    modport master (
        output i_lsu_valid, i_lsu_op, i_lsu_addr, i_lsu_wdata, i_lsu_rd,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_lsu_ready,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        input  o_wb_en, o_wb_addr, o_wb_data, o_exc, o_exc_cause, o_busy
    );

endinterface

// File: rtl/lsu_data_align.sv
// Byte-lane datapath: store replication/byte enables, access legality, load shift and extension.
// Purely combinational, zero latency.
// No flow control; the owning FSM decides when results are captured.
module lsu_data_align
    import arriskv_pkg::*;
#(
    parameter int wd_regs_p = 32
) (
    input  logic                 i_acc_store,
    input  logic [1:0]           i_acc_size,
    input  logic [1:0]           i_acc_off,
    input  logic [wd_regs_p-1:0] i_st_wdata,
    output logic [3:0]           o_be,
    output logic [wd_regs_p-1:0] o_wdata,
    output logic                 o_misaligned,
    output logic                 o_illegal,

    input  logic [1:0]           i_ld_size,
    input  logic                 i_ld_unsigned,
    input  logic [1:0]           i_ld_off,
    input  logic [wd_regs_p-1:0] i_rdata,
    output logic [wd_regs_p-1:0] o_ld_data
);

    logic [wd_regs_p-1:0] w_shift;

    always_comb begin
        o_illegal    = (i_acc_size == 2'b11);
        o_misaligned = ((i_acc_size == MEM_H) && i_acc_off[0]) ||
                       ((i_acc_size == MEM_W) && (i_acc_off != 2'b00));
        o_be         = 4'b1111;
        o_wdata      = i_st_wdata;
        // Memory picks the live lane via be, so the narrow datum is copied to every lane
        if (i_acc_store) begin
            case (i_acc_size)
                MEM_B: begin
                    o_be    = 4'b0001 << i_acc_off;
                    o_wdata = {4{i_st_wdata[7:0]}};
                end
                MEM_H: begin
                    o_be    = 4'b0011 << i_acc_off;
                    o_wdata = {2{i_st_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_size)
            MEM_B:   o_ld_data = i_ld_unsigned ? {24'b0, w_shift[7:0]}
                                               : {{24{w_shift[7]}}, w_shift[7:0]};
            MEM_H:   o_ld_data = i_ld_unsigned ? {16'b0, w_shift[15:0]}
                                               : {{16{w_shift[15]}}, w_shift[15:0]};
            default: o_ld_data = w_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns one execute op into a data-memory access and a load writeback.
// Store occupies >=2 cycles, load >=3 cycles accept-to-writeback; illegal ops raise o_exc next cycle.
// Accepts only in IDLE (o_lsu_ready); holds the request stable until i_mem_gnt.
module load_store_unit
    import arriskv_pkg::*;
#(
    parameter int wd_regs_p    = 32,
    parameter int n_regs_p     = 32,
    parameter int wd_ramaddr_p = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    localparam int wd_addr_p = $clog2(n_regs_p);

    lsu_state_e              r_state;
    lsu_state_e              w_state_nxt;
    mem_op_t                 r_op;
    logic [1:0]              r_off;
    logic [wd_addr_p-1:0]    r_rd;
    logic [wd_ramaddr_p-1:0] r_mem_addr;
    logic [3:0]              r_mem_be;
    logic [wd_regs_p-1:0]    r_mem_wdata;
    logic                    r_wb_en;
    logic [wd_addr_p-1:0]    r_wb_addr;
    logic [wd_regs_p-1:0]    r_wb_data;
    logic                    r_exc;
    lsu_exc_e                r_exc_cause;

    logic                    w_take_op;
    logic                    w_exc_nxt;
    logic                    w_wb_fire;
    logic [3:0]              w_be;
    logic [wd_regs_p-1:0]    w_wdata;
    logic                    w_misaligned;
    logic                    w_illegal;
    logic [wd_regs_p-1:0]    w_ld_data;

    lsu_data_align #(.wd_regs_p(wd_regs_p)) u_align (
        .i_acc_store   (bus.i_lsu_op.is_store),
        .i_acc_size    (bus.i_lsu_op.size),
        .i_acc_off     (bus.i_lsu_addr[1:0]),
        .i_st_wdata    (bus.i_lsu_wdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_misaligned  (w_misaligned),
        .o_illegal     (w_illegal),
        .i_ld_size     (r_op.size),
        .i_ld_unsigned (r_op.is_unsigned),
        .i_ld_off      (r_off),
        .i_rdata       (bus.i_mem_rdata),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_op   = 1'b0;
        w_exc_nxt   = 1'b0;
        w_wb_fire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_lsu_valid) begin
                    if (w_illegal || w_misaligned) begin
                        w_exc_nxt = 1'b1;
                    end else begin
                        w_take_op   = 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.i_mem_gnt) begin
                    w_state_nxt = r_op.is_store ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus.i_mem_rvalid) begin
                    w_wb_fire   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= '0;
            r_off       <= '0;
            r_rd        <= '0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_exc       <= 1'b0;
            r_exc_cause <= EXC_MISALIGNED;
        end else begin
            r_exc   <= w_exc_nxt;
            // x0 is hardwired: the access still happens but nothing is written back
            r_wb_en <= w_wb_fire && (r_rd != '0);
            if (w_exc_nxt) begin
                r_exc_cause <= w_illegal ? EXC_ILLEGAL_SIZE : EXC_MISALIGNED;
            end
            if (w_take_op) begin
                r_op        <= bus.i_lsu_op;
                r_off       <= bus.i_lsu_addr[1:0];
                r_rd        <= bus.i_lsu_rd;
                r_mem_addr  <= {bus.i_lsu_addr[wd_ramaddr_p-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end
            if (w_wb_fire) begin
                r_wb_addr <= r_rd;
                r_wb_data <= w_ld_data;
            end
        end
    end

    assign bus.o_lsu_ready = (r_state == IDLE);
    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_mem_req   = (r_state == REQ);
    assign bus.o_mem_we    = r_op.is_store;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_be    = r_mem_be;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_wb_en     = r_wb_en;
    assign bus.o_wb_addr   = r_wb_addr;
    assign bus.o_wb_data   = r_wb_data;
    assign bus.o_exc       = r_exc;
    assign bus.o_exc_cause = r_exc_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of ops plus reset-during-WAIT sequence.
module tb_load_store_unit;
    import arriskv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.wd_regs_p(32), .n_regs_p(32), .wd_ramaddr_p(32)) bus ();

    load_store_unit #(.wd_regs_p(32), .n_regs_p(32), .wd_ramaddr_p(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        exp_exc;
        logic        exp_cause;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mem_op_t mk_op(input logic st, input logic uns, input logic [1:0] sz);
        return mem_op_t'({st, uns, sz});
    endfunction

    function automatic vec_t mkv(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                                 input int rv_dly, input logic exc, input logic cause,
                                 input logic [31:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewdata,
                                 input logic ewb, input logic [31:0] ewbdata);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.exp_exc = exc; v.exp_cause = cause;
        v.exp_addr = eaddr; v.exp_be = ebe; v.exp_wdata = ewdata;
        v.exp_wb = ewb; v.exp_wb_data = ewbdata;
        return v;
    endfunction

    task automatic check_req(input string tag, input vec_t v);
        check({tag, "/req"},  bus.o_mem_req, 1'b1);
        check({tag, "/we"},   bus.o_mem_we, v.op.is_store);
        check({tag, "/addr"}, bus.o_mem_addr, v.exp_addr);
        check({tag, "/be"},   bus.o_mem_be, v.exp_be);
        if (v.op.is_store) check({tag, "/wdata"}, bus.o_mem_wdata, v.exp_wdata);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        check({tag, "/ready"}, bus.o_lsu_ready, 1'b1);
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_op    = v.op;
        bus.i_lsu_addr  = v.addr;
        bus.i_lsu_wdata = v.wdata;
        bus.i_lsu_rd    = v.rd;
        step();
        // scramble execute inputs: the LSU must work from what it captured
        bus.i_lsu_valid = 1'b0;
        bus.i_lsu_op    = mk_op(1'b0, 1'b0, 2'b11);
        bus.i_lsu_addr  = 32'hFFFF_FFFF;
        bus.i_lsu_wdata = 32'h0;
        bus.i_lsu_rd    = 5'h1f;
        if (v.exp_exc) begin
            check({tag, "/exc"},   bus.o_exc, 1'b1);
            check({tag, "/cause"}, bus.o_exc_cause, v.exp_cause);
            check({tag, "/noreq"}, bus.o_mem_req, 1'b0);
            check({tag, "/idle"},  bus.o_busy, 1'b0);
            step();
            check({tag, "/exc_pulse"}, bus.o_exc, 1'b0);
            check({tag, "/noreq2"},    bus.o_mem_req, 1'b0);
        end else begin
            check({tag, "/busy"}, bus.o_busy, 1'b1);
            check({tag, "/noexc"}, bus.o_exc, 1'b0);
            check_req(tag, v);
            for (int i = 0; i < v.gnt_dly; i++) begin
                step();
                check_req($sformatf("%s/stall%0d", tag, i), v);
            end
            bus.i_mem_gnt    = 1'b1;
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = 32'h5555_5555;
            step();
            bus.i_mem_gnt    = 1'b0;
            bus.i_mem_rvalid = 1'b0;
            check({tag, "/req_drop"}, bus.o_mem_req, 1'b0);
            check({tag, "/wb_gnt"},   bus.o_wb_en, 1'b0);
            if (v.op.is_store) begin
                check({tag, "/st_idle"}, bus.o_lsu_ready, 1'b1);
            end else begin
                check({tag, "/ld_wait"}, bus.o_busy, 1'b1);
                for (int i = 1; i < v.rv_dly; i++) begin
                    step();
                    check($sformatf("%s/wait%0d", tag, i), bus.o_wb_en, 1'b0);
                end
                bus.i_mem_rvalid = 1'b1;
                bus.i_mem_rdata  = v.rdata;
                step();
                bus.i_mem_rvalid = 1'b0;
                bus.i_mem_rdata  = 32'hA5A5_A5A5;
                check({tag, "/wb_en"}, bus.o_wb_en, v.exp_wb);
                if (v.exp_wb) begin
                    check({tag, "/wb_addr"}, bus.o_wb_addr, v.rd);
                    check({tag, "/wb_data"}, bus.o_wb_data, v.exp_wb_data);
                end
                check({tag, "/ld_idle"}, bus.o_busy, 1'b0);
                step();
                check({tag, "/wb_pulse"}, bus.o_wb_en, 1'b0);
            end
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t sw_after;
        rst = 1'b1;
        bus.i_lsu_valid  = 1'b0;
        bus.i_lsu_op     = '0;
        bus.i_lsu_addr   = '0;
        bus.i_lsu_wdata  = '0;
        bus.i_lsu_rd     = '0;
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;

        //            op                     addr          wdata         rd  rdata         g  r  exc cau eaddr         be       ewdata        wb   wbdata
        vecs.push_back(mkv(mk_op(1,0,2'd2), 32'h100, 32'hDEADBEEF, 0,  32'h0,        3, 1, 0,  0,  32'h100, 4'b1111, 32'hDEADBEEF, 0,  32'h0));
        vecs.push_back(mkv(mk_op(1,0,2'd0), 32'h103, 32'h000000A5, 0,  32'h0,        0, 1, 0,  0,  32'h100, 4'b1000, 32'hA5A5A5A5, 0,  32'h0));
        vecs.push_back(mkv(mk_op(1,0,2'd0), 32'h101, 32'h1234563C, 0,  32'h0,        0, 1, 0,  0,  32'h100, 4'b0010, 32'h3C3C3C3C, 0,  32'h0));
        vecs.push_back(mkv(mk_op(1,0,2'd1), 32'h102, 32'h1234BEEF, 0,  32'h0,        1, 1, 0,  0,  32'h100, 4'b1100, 32'hBEEFBEEF, 0,  32'h0));
        vecs.push_back(mkv(mk_op(0,0,2'd0), 32'h202, 32'h0,        7,  32'h12F03456, 0, 2, 0,  0,  32'h200, 4'b1111, 32'h0,        1,  32'hFFFFFFF0));
        vecs.push_back(mkv(mk_op(0,1,2'd0), 32'h202, 32'h0,        7,  32'h12F03456, 0, 2, 0,  0,  32'h200, 4'b1111, 32'h0,        1,  32'h000000F0));
        vecs.push_back(mkv(mk_op(0,0,2'd1), 32'h202, 32'h0,        3,  32'h80010000, 0, 1, 0,  0,  32'h200, 4'b1111, 32'h0,        1,  32'hFFFF8001));
        vecs.push_back(mkv(mk_op(0,1,2'd1), 32'h202, 32'h0,        3,  32'h80010000, 0, 1, 0,  0,  32'h200, 4'b1111, 32'h0,        1,  32'h00008001));
        vecs.push_back(mkv(mk_op(0,0,2'd0), 32'h201, 32'h0,        9,  32'h00007F00, 1, 1, 0,  0,  32'h200, 4'b1111, 32'h0,        1,  32'h0000007F));
        vecs.push_back(mkv(mk_op(0,0,2'd2), 32'h300, 32'h0,        0,  32'hCAFEBABE, 0, 1, 0,  0,  32'h300, 4'b1111, 32'h0,        0,  32'h0));
        vecs.push_back(mkv(mk_op(0,0,2'd2), 32'h304, 32'h0,        31, 32'hCAFEBABE, 0, 3, 0,  0,  32'h304, 4'b1111, 32'h0,        1,  32'hCAFEBABE));
        vecs.push_back(mkv(mk_op(0,0,2'd1), 32'h201, 32'h0,        4,  32'h0,        0, 1, 1,  0,  32'h0,   4'b0000, 32'h0,        0,  32'h0));
        vecs.push_back(mkv(mk_op(0,0,2'd3), 32'h200, 32'h0,        4,  32'h0,        0, 1, 1,  1,  32'h0,   4'b0000, 32'h0,        0,  32'h0));
        vecs.push_back(mkv(mk_op(1,0,2'd2), 32'h102, 32'h11223344, 0,  32'h0,        0, 1, 1,  0,  32'h0,   4'b0000, 32'h0,        0,  32'h0));

        step();
        step();
        check("rst/ready", bus.o_lsu_ready, 1'b1);
        check("rst/busy",  bus.o_busy, 1'b0);
        check("rst/req",   bus.o_mem_req, 1'b0);
        check("rst/wb_en", bus.o_wb_en, 1'b0);
        check("rst/exc",   bus.o_exc, 1'b0);
        check("rst/addr",  bus.o_mem_addr, 32'h0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // reset while a load waits for data: the late rvalid must not write back
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_op    = mk_op(0, 0, 2'd2);
        bus.i_lsu_addr  = 32'h400;
        bus.i_lsu_rd    = 5'd5;
        step();
        bus.i_lsu_valid = 1'b0;
        bus.i_mem_gnt   = 1'b1;
        step();
        bus.i_mem_gnt   = 1'b0;
        check("rstw/in_wait", bus.o_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw/ready", bus.o_lsu_ready, 1'b1);
        check("rstw/busy",  bus.o_busy, 1'b0);
        check("rstw/req",   bus.o_mem_req, 1'b0);
        check("rstw/addr",  bus.o_mem_addr, 32'h0);
        check("rstw/be",    bus.o_mem_be, 4'h0);
        check("rstw/we",    bus.o_mem_we, 1'b0);
        check("rstw/wb_en", bus.o_wb_en, 1'b0);
        step();
        rst = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'h1234_5678;
        step();
        bus.i_mem_rvalid = 1'b0;
        check("rstw/late_rv", bus.o_wb_en, 1'b0);
        step();
        check("rstw/late_rv2", bus.o_wb_en, 1'b0);
        check("rstw/idle",     bus.o_busy, 1'b0);

        sw_after = mkv(mk_op(1,0,2'd2), 32'h500, 32'h0BADF00D, 0, 32'h0, 1, 1, 0, 0,
                       32'h500, 4'b1111, 32'h0BADF00D, 0, 32'h0);
        run_vec(sw_after, "post_rst_sw");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
